if_fetch_ctrl: RTL and testbench
================================

// Module: if_fetch_ctrl
// PURPOSE
//   Sequencing controller for the IF stage (PC register, NPC select mux, instruction memory).
//   - Drives the PC write enable, the 2-bit next-PC select, the IF/ID write enable and the IF/ID flush.
//   - Handles instruction-memory wait states, hazard stalls and jump/branch redirects.
//   - A redirect that arrives while a fetch cannot complete is latched and applied at the next completing fetch.
// PARAMETERS
//   BOOT_CYCLES  2   idle cycles after reset release before the first fetch request (0 = none)
//   CNT_W        16  width of the fetch_cnt performance counter
// PORTS
//   clk           in   1      clock; all state updates on posedge
//   rst           in   1      asynchronous, active-high reset
//   imem_req      out  1      fetch request to instruction memory at current PC
//   imem_ready    in   1      instruction-memory data valid this cycle
//   stall         in   1      load-use hazard: hold PC and IF/ID
//   jump          in   1      jump redirect request; target held stable by requester until redirect_ack
//   branch_taken  in   1      taken-branch redirect request; target held stable until redirect_ack
//   PCWr          out  1      PC write enable
//   NPCOp         out  2      next-PC select: 00 PC+4, 01 jump, 10 branch (11 never driven)
//   ifid_wr       out  1      IF/ID pipeline register write enable
//   ifid_flush    out  1      IF/ID flush (insert bubble)
//   redirect_ack  out  1      one-cycle pulse: pending/live redirect consumed
//   fetch_cnt     out  CNT_W  count of completed fetches
// BEHAVIOUR
//   States: BOOT, FETCH, WAIT, HOLD.
//   Reset (async): state=BOOT, boot counter=BOOT_CYCLES, pend_v=0, pend_op=00, fetch_cnt=0.
//     All outputs are 0 while rst is high; imem_req drops in the same cycle rst rises.
//   BOOT: counter decrements each cycle; at 0 go to FETCH (BOOT_CYCLES=0 -> FETCH on first clock).
//     Redirect inputs are ignored in BOOT.
//   FETCH/WAIT: imem_req=1 (combinational from state).
//   eff_op: priority order, highest first -> live branch_taken=10, live jump=01, pend_op if pend_v, else 00.
//   redir = branch_taken | jump | pend_v.
//   Completion = imem_ready & (!stall | redir). Redirect/flush beats stall. On completion, same cycle:
//     - PCWr=1, ifid_wr=1, NPCOp=eff_op.
//     - ifid_flush=redir; redirect_ack=redir.
//     - fetch_cnt+1 on next edge; wraps modulo 2^CNT_W.
//     - pend_v cleared; next state FETCH.
//   FETCH/WAIT, !imem_ready: PCWr=ifid_wr=0, NPCOp=00, imem_req held; next state WAIT.
//   FETCH/WAIT, imem_ready & stall & !redir: no writes; next state HOLD.
//   HOLD: imem_req=0, no writes; stall=0 -> FETCH (same PC refetched).
//     In HOLD, redirect plus !stall also -> FETCH.
//   Redirect capture (any non-BOOT state, not completing): branch_taken -> pend_op=10, pend_v=1;
//     jump -> pend_op=01 only if pend_v=0. A pending branch is never overwritten.
//     Branch and jump together -> branch.
//   Outputs other than fetch_cnt are combinational from state, pend regs and inputs.
//     No combinational path from imem_ready to imem_req.
//   Latency: completing fetch updates PC on the same edge; zero-wait memory gives 1 fetch/cycle.
// TESTING
//   rst 1->0, BOOT_CYCLES=2, imem_ready=1 -> imem_req first high 2 cycles after release;
//     then PCWr=1, NPCOp=00 every cycle; fetch_cnt=1,2,3...
//   imem_ready low 3 cycles mid-run -> WAIT for 3 cycles, PCWr=0, imem_req=1;
//     completes on 4th cycle; fetch_cnt +1 only.
//   jump pulse 1 cycle during WAIT, ready 2 cycles later -> completing cycle NPCOp=01,
//     ifid_flush=1, redirect_ack=1.
//   jump then branch_taken while waiting -> completion NPCOp=10.
//   branch then jump while waiting -> completion NPCOp=10.
//   stall=1 with imem_ready=1 for 2 cycles -> HOLD, PCWr=ifid_wr=0.
//     stall=1 plus branch_taken=1 -> PCWr=1, NPCOp=10, ifid_flush=1 (flush beats stall).
//   rst asserted during WAIT with pend_v=1 -> imem_req=0 immediately;
//     after release: pend cleared, fetch_cnt=0, first completion NPCOp=00.
//   CNT_W=4: 17 completions -> fetch_cnt=1.

Source files
------------

// File: rtl/if_fetch_ctrl.sv
// IF-stage sequencing controller: drives PC write, next-PC select and IF/ID control,
// absorbing instruction-memory wait states, hazard stalls and jump/branch redirects.
module if_fetch_ctrl #(
  parameter int unsigned BOOT_CYCLES = 2,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  input  logic             imem_ready,
  input  logic             stall,
  input  logic             jump,
  input  logic             branch_taken,
  output logic             PCWr,
  output logic [1:0]       NPCOp,
  output logic             ifid_wr,
  output logic             ifid_flush,
  output logic             redirect_ack,
  output logic [CNT_W-1:0] fetch_cnt
);

  localparam int unsigned BW = (BOOT_CYCLES > 0) ? $clog2(BOOT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {S_BOOT, S_FETCH, S_WAIT, S_HOLD} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [BW-1:0]    r_boot_cnt;
  logic             r_pend_v;
  logic [1:0]       r_pend_op;
  logic [CNT_W-1:0] r_fetch_cnt;

  logic             w_active;
  logic             w_redir;
  logic             w_done;
  logic [1:0]       w_eff_op;
  logic             w_pend_v_nx;
  logic [1:0]       w_pend_op_nx;

  always_comb begin
    w_active = (r_state == S_FETCH) || (r_state == S_WAIT);
    w_redir  = branch_taken | jump | r_pend_v;
    if (branch_taken)  w_eff_op = 2'b10;
    else if (jump)     w_eff_op = 2'b01;
    else if (r_pend_v) w_eff_op = r_pend_op;
    else               w_eff_op = 2'b00;
    // A redirect completes even under stall: the flushed slot makes the hazard moot.
    w_done = w_active & imem_ready & (~stall | w_redir);

    imem_req     = w_active;
    PCWr         = w_done;
    ifid_wr      = w_done;
    NPCOp        = w_done ? w_eff_op : 2'b00;
    ifid_flush   = w_done & w_redir;
    redirect_ack = w_done & w_redir;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_BOOT:  if (r_boot_cnt <= BW'(1)) w_next = S_FETCH;
      S_FETCH,
      S_WAIT: begin
        if (w_done)           w_next = S_FETCH;
        else if (!imem_ready) w_next = S_WAIT;
        else                  w_next = S_HOLD;
      end
      S_HOLD:  if (!stall) w_next = S_FETCH;
      default: w_next = S_BOOT;
    endcase
  end

  // A pending branch outranks any later jump; a pending jump yields to a later branch.
  always_comb begin
    w_pend_v_nx  = r_pend_v;
    w_pend_op_nx = r_pend_op;
    if (w_done) begin
      w_pend_v_nx  = 1'b0;
      w_pend_op_nx = 2'b00;
    end else if (r_state != S_BOOT) begin
      if (branch_taken) begin
        w_pend_v_nx  = 1'b1;
        w_pend_op_nx = 2'b10;
      end else if (jump && !r_pend_v) begin
        w_pend_v_nx  = 1'b1;
        w_pend_op_nx = 2'b01;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_BOOT;
      r_boot_cnt  <= BW'(BOOT_CYCLES);
      r_pend_v    <= 1'b0;
      r_pend_op   <= 2'b00;
      r_fetch_cnt <= '0;
    end else begin
      r_state   <= w_next;
      r_pend_v  <= w_pend_v_nx;
      r_pend_op <= w_pend_op_nx;
      if (r_state == S_BOOT && r_boot_cnt != '0) r_boot_cnt <= r_boot_cnt - BW'(1);
      if (w_done) r_fetch_cnt <= r_fetch_cnt + CNT_W'(1);
    end
  end

  assign fetch_cnt = r_fetch_cnt;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: directed vector table, random stimulus against a reference
// model of the fetch rules, then reset-during-wait and 4-bit counter wrap sequences.
module tb_if_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_ready, stall, jump, branch_taken;
  logic        imem_req, PCWr, ifid_wr, ifid_flush, redirect_ack;
  logic [1:0]  NPCOp;
  logic [15:0] fetch_cnt;
  logic        imem_req4, PCWr4, ifid_wr4, ifid_flush4, redirect_ack4;
  logic [1:0]  NPCOp4;
  logic [3:0]  fetch_cnt4;

  always #5 clk = ~clk;

  if_fetch_ctrl #(.BOOT_CYCLES(2), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_ready(imem_ready), .stall(stall),
    .jump(jump), .branch_taken(branch_taken), .PCWr(PCWr), .NPCOp(NPCOp), .ifid_wr(ifid_wr),
    .ifid_flush(ifid_flush), .redirect_ack(redirect_ack), .fetch_cnt(fetch_cnt));

  if_fetch_ctrl #(.BOOT_CYCLES(2), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .imem_req(imem_req4), .imem_ready(imem_ready), .stall(stall),
    .jump(jump), .branch_taken(branch_taken), .PCWr(PCWr4), .NPCOp(NPCOp4), .ifid_wr(ifid_wr4),
    .ifid_flush(ifid_flush4), .redirect_ack(redirect_ack4), .fetch_cnt(fetch_cnt4));

  // {imem_req, PCWr, ifid_wr, NPCOp, ifid_flush, redirect_ack}
  logic [6:0] outs, outs4;
  assign outs  = {imem_req, PCWr, ifid_wr, NPCOp, ifid_flush, redirect_ack};
  assign outs4 = {imem_req4, PCWr4, ifid_wr4, NPCOp4, ifid_flush4, redirect_ack4};

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: idle cycles left, parked-after-stall flag, pending redirect kind
  // (0 none, 1 jump, 2 branch) and total completed fetches.
  int m_boot, m_pend, m_cnt;
  bit m_held;

  typedef struct packed {
    logic [3:0] in;   // {stall, imem_ready, jump, branch_taken}
    logic [6:0] ex;
  } vec_t;
  vec_t tbl [25];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_boot = 2;
    m_held = 1'b0;
    m_pend = 0;
    m_cnt  = 0;
  endtask

  function automatic logic [6:0] model_expect(input logic st, input logic rdy,
                                              input logic jp, input logic br);
    logic redir, done;
    logic [1:0] op;
    if (m_boot > 0 || m_held) return 7'b0000000;
    redir = jp | br | (m_pend != 0);
    done  = rdy && (!st || redir);
    op    = br ? 2'd2 : (jp ? 2'd1 : 2'(m_pend));
    if (!done) return 7'b1000000;
    return {3'b111, op, redir, redir};
  endfunction

  task automatic model_step(input logic st, input logic rdy, input logic jp, input logic br);
    logic redir, done;
    if (m_boot > 0) begin
      m_boot--;
      return;
    end
    redir = jp | br | (m_pend != 0);
    done  = !m_held && rdy && (!st || redir);
    if (done) begin
      m_cnt++;
      m_pend = 0;
      return;
    end
    if (br) m_pend = 2;
    else if (jp && m_pend == 0) m_pend = 1;
    if (m_held) begin
      if (!st) m_held = 1'b0;
    end else if (rdy) begin
      m_held = 1'b1;
    end
  endtask

  task automatic run(input logic [3:0] in, input bit use_t, input logic [6:0] tex,
                     input string tag);
    logic [6:0] ex;
    {stall, imem_ready, jump, branch_taken} = in;
    ex = use_t ? tex : model_expect(in[3], in[2], in[1], in[0]);
    @(negedge clk);
    chk({tag, " outs"},  32'(outs),  32'(ex));
    chk({tag, " outs4"}, 32'(outs4), 32'(ex));
    chk({tag, " cnt"},   32'(fetch_cnt),  32'(m_cnt & 16'hffff));
    chk({tag, " cnt4"},  32'(fetch_cnt4), 32'(m_cnt & 4'hf));
    @(posedge clk);
    model_step(in[3], in[2], in[1], in[0]);
    #1;
  endtask

  initial begin
    tbl[0]  = '{4'b0100, 7'b0000000};  // boot idle
    tbl[1]  = '{4'b0100, 7'b0000000};
    tbl[2]  = '{4'b0100, 7'b1110000};  // first fetch
    tbl[3]  = '{4'b0100, 7'b1110000};
    tbl[4]  = '{4'b0100, 7'b1110000};
    tbl[5]  = '{4'b0000, 7'b1000000};  // 3 wait states
    tbl[6]  = '{4'b0000, 7'b1000000};
    tbl[7]  = '{4'b0000, 7'b1000000};
    tbl[8]  = '{4'b0100, 7'b1110000};
    tbl[9]  = '{4'b0010, 7'b1000000};  // jump while waiting
    tbl[10] = '{4'b0000, 7'b1000000};
    tbl[11] = '{4'b0100, 7'b1110111};
    tbl[12] = '{4'b0010, 7'b1000000};  // jump then branch
    tbl[13] = '{4'b0001, 7'b1000000};
    tbl[14] = '{4'b0100, 7'b1111011};
    tbl[15] = '{4'b0001, 7'b1000000};  // branch then jump
    tbl[16] = '{4'b0010, 7'b1000000};
    tbl[17] = '{4'b0100, 7'b1111011};
    tbl[18] = '{4'b1100, 7'b1000000};  // stall -> hold
    tbl[19] = '{4'b1100, 7'b0000000};
    tbl[20] = '{4'b0100, 7'b0000000};
    tbl[21] = '{4'b1101, 7'b1111011};  // stall + branch: flush wins
    tbl[22] = '{4'b0100, 7'b1110000};
    tbl[23] = '{4'b0110, 7'b1110111};  // live jump
    tbl[24] = '{4'b0111, 7'b1111011};  // live branch beats jump

    rst = 1'b1;
    {stall, imem_ready, jump, branch_taken} = 4'b0100;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("reset outs",  32'(outs),  32'd0);
      chk("reset outs4", 32'(outs4), 32'd0);
      chk("reset cnt",   32'(fetch_cnt), 32'd0);
    end
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 25; i++)
      run(tbl[i].in, 1'b1, tbl[i].ex, $sformatf("tbl[%0d]", i));

    for (int i = 0; i < 1500; i++) begin
      logic [3:0] in;
      in[3] = ($urandom_range(0, 3) == 0);
      in[2] = ($urandom_range(0, 9) < 7);
      in[1] = ($urandom_range(0, 9) == 0);
      in[0] = ($urandom_range(0, 9) == 0);
      run(in, 1'b0, 7'b0, "rand");
    end

    // Park in WAIT with a pending jump, then assert reset mid-cycle.
    run(4'b0000, 1'b0, 7'b0, "pre-rst");
    run(4'b0000, 1'b0, 7'b0, "pre-rst");
    run(4'b0010, 1'b0, 7'b0, "pre-rst jump");
    {stall, imem_ready, jump, branch_taken} = 4'b0000;
    #2;
    chk("pre-rst req", 32'(imem_req), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst req drop",  32'(outs),  32'd0);
    chk("rst req drop4", 32'(outs4), 32'd0);
    chk("rst cnt",       32'(fetch_cnt), 32'd0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    run(4'b0100, 1'b0, 7'b0, "post-rst boot");
    run(4'b0100, 1'b0, 7'b0, "post-rst boot");
    run(4'b0100, 1'b1, 7'b1110000, "post-rst first");
    for (int i = 0; i < 16; i++)
      run(4'b0100, 1'b0, 7'b0, "wrap");
    chk("wrap cnt4",  32'(fetch_cnt4), 32'd1);
    chk("wrap cnt16", 32'(fetch_cnt),  32'd17);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
